gon_bus: RTL



---
 rtl/gon_bus_if.sv | 27 ++
 rtl/gon_bus.sv | 69 ++++++
 2 files changed

// File: rtl/gon_bus_if.sv
// gon_bus_if: sink request/response and source pop/data bundle for the gather bus
interface gon_bus_if #(
    parameter int BITWIDTH    = 16,
    parameter int TAG_LENGTH  = 4,
    parameter int NUM_SOURCES = 4
);
    logic                            bus_enable;
    logic [TAG_LENGTH-1:0]           tag;
    logic                            bus_ready;
    logic [NUM_SOURCES-1:0]          source_valid;
    logic [BITWIDTH*NUM_SOURCES-1:0] source_data;
    logic [NUM_SOURCES-1:0]          source_enable;
    logic                            output_valid;
    logic [BITWIDTH-1:0]             output_value;
    logic                            output_ready;
    logic                            tag_miss;

    modport master (
        output bus_enable, tag, source_valid, source_data, output_ready,
        input  bus_ready, source_enable, output_valid, output_value, tag_miss
    );

    modport slave (
        input  bus_enable, tag, source_valid, source_data, output_ready,
        output bus_ready, source_enable, output_valid, output_value, tag_miss
    );
endinterface

// File: rtl/gon_bus.sv
// gon_bus: tag-matched gather of source words to a single sink, with a scan-programmed slot ID chain
module gon_bus #(
    parameter int BITWIDTH    = 16,
    parameter int TAG_LENGTH  = 4,
    parameter int NUM_SOURCES = 4
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  program_en,
    input  logic [TAG_LENGTH-1:0] scan_tag_in,
    output logic [TAG_LENGTH-1:0] scan_tag_next_bus,
    gon_bus_if.slave              bus
);
    localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, HOLD = 2'd2;

    logic [1:0]             state;
    logic [TAG_LENGTH-1:0]  id [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] mask, match, low;
    logic [BITWIDTH-1:0]    sel_data;
    logic                   accept, pop;

    assign low                = mask & -mask;
    assign pop                = state == SCAN && |(low & bus.source_valid);
    assign accept             = state == IDLE && bus.bus_enable && !program_en;
    assign bus.source_enable  = pop ? low : '0;
    assign bus.bus_ready      = state == IDLE;
    assign bus.output_valid   = state == HOLD;
    assign scan_tag_next_bus  = id[NUM_SOURCES-1];

    // per-slot tag compare and data mux of the lowest pending slot
    always_comb begin
        match    = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            match[i] = id[i] == bus.tag;
            sel_data = sel_data | (low[i] ? bus.source_data[BITWIDTH*i +: BITWIDTH] : '0);
        end
    end

    // slot ID scan chain, shiftable in any state
    always_ff @(posedge clk or negedge rstb)
        if (!rstb) id <= '{default: '0};
        else if (program_en) begin
            id[0] <= scan_tag_in;
            for (int i = 1; i < NUM_SOURCES; i++) id[i] <= id[i-1];
        end

    // request latch, in-order drain of matched slots and sink hold
    always_ff @(posedge clk or negedge rstb)
        if (!rstb) begin
            state            <= IDLE;
            mask             <= '0;
            bus.output_value <= '0;
            bus.tag_miss     <= 1'b0;
        end else begin
            bus.tag_miss <= accept && match == '0;
            if (accept) begin
                mask  <= match;
                state <= |match ? SCAN : IDLE;
            end else if (state == SCAN) begin
                if (mask == '0) state <= IDLE;
                else if (pop) begin
                    bus.output_value <= sel_data;
                    mask             <= mask & ~low;
                    state            <= HOLD;
                end
            end else if (state == HOLD && bus.output_ready) state <= SCAN;
        end
endmodule
